// File: rtl/race_arbiter_array_if.sv
// Race arbiter array bundle: launch, per-channel path arrivals, and valid/ready result readout.
interface race_arbiter_array_if #(
  parameter int N_PAIRS = 8
);
  logic               start;
  logic [N_PAIRS-1:0] finished1;
  logic [N_PAIRS-1:0] finished2;
  logic               busy;
  logic               resp_valid;
  logic               resp_ready;
  logic [N_PAIRS-1:0] response;
  logic [N_PAIRS-1:0] tie;
  logic [N_PAIRS-1:0] unresolved;
  logic               timeout;

  modport master (
    output start, finished1, finished2, resp_ready,
    input  busy, resp_valid, response, tie, unresolved, timeout
  );

  modport slave (
    input  start, finished1, finished2, resp_ready,
    output busy, resp_valid, response, tie, unresolved, timeout
  );
endinterface

// File: rtl/race_arbiter_array.sv
// Parallel clocked race arbiter: arrival to decision = SYNC_STAGES+1 cycles, report 1 cycle later at most.
// Result is held in REPORT until resp_ready; start is ignored while ARMED or REPORT.
module race_arbiter_array #(
  parameter int N_PAIRS        = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  race_arbiter_array_if.slave  arb
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARMED, REPORT} state_t;

  state_t state;
  logic [SYNC_STAGES-1:0][N_PAIRS-1:0] sync1;
  logic [SYNC_STAGES-1:0][N_PAIRS-1:0] sync2;
  logic [N_PAIRS-1:0] decided;
  logic [N_PAIRS-1:0] response_q;
  logic [N_PAIRS-1:0] tie_q;
  logic [N_PAIRS-1:0] unresolved_q;
  logic               timeout_q;
  logic               busy_q;
  logic               valid_q;
  logic [CW-1:0]      cnt;

  logic [N_PAIRS-1:0] s1;
  logic [N_PAIRS-1:0] s2;
  logic [N_PAIRS-1:0] win1;
  logic [N_PAIRS-1:0] both;
  logic [N_PAIRS-1:0] seen;

  // Synchronisers run continuously so the chain is settled by the time start arrives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {sync1[SYNC_STAGES-2:0], arb.finished1};
      sync2 <= {sync2[SYNC_STAGES-2:0], arb.finished2};
    end
  end

  assign s1   = sync1[SYNC_STAGES-1];
  assign s2   = sync2[SYNC_STAGES-1];
  assign win1 = ~decided & s1 & ~s2;
  assign both = ~decided & s1 & s2;
  assign seen = decided | s1 | s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      decided      <= '0;
      response_q   <= '0;
      tie_q        <= '0;
      unresolved_q <= '0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      cnt          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb.start) begin
            state        <= ARMED;
            busy_q       <= 1'b1;
            decided      <= '0;
            response_q   <= '0;
            tie_q        <= '0;
            unresolved_q <= '0;
            timeout_q    <= 1'b0;
            cnt          <= '0;
          end
        end
        ARMED: begin
          decided    <= seen;
          response_q <= response_q | win1;
          tie_q      <= tie_q | both;
          // A last decision landing on the timeout cycle still counts as a clean finish.
          if (&seen) begin
            state     <= REPORT;
            valid_q   <= 1'b1;
            timeout_q <= 1'b0;
          end else if (cnt == CNT_MAX) begin
            state        <= REPORT;
            valid_q      <= 1'b1;
            timeout_q    <= 1'b1;
            unresolved_q <= ~seen;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REPORT: begin
          if (arb.resp_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign arb.busy       = busy_q;
  assign arb.resp_valid = valid_q;
  assign arb.response   = response_q;
  assign arb.tie        = tie_q;
  assign arb.unresolved = unresolved_q;
  assign arb.timeout    = timeout_q;

endmodule

// File: tb/tb_race_arbiter_array.sv
// Directed bench for race_arbiter_array with N_PAIRS=8, SYNC_STAGES=2, TIMEOUT_CYCLES=16.
module tb_race_arbiter_array;
  localparam int N    = 8;
  localparam int SYNC = 2;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  race_arbiter_array_if #(.N_PAIRS(N)) bus ();

  race_arbiter_array #(
    .N_PAIRS(N), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .arb(bus.slave)
  );

  int checks = 0;
  int fails  = 0;
  int f1_at[N];
  int f2_at[N];
  int lat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle k input values: each channel rises at its scheduled cycle and stays high (-1 = never).
  task automatic apply(input int k);
    for (int i = 0; i < N; i++) begin
      bus.finished1[i] = (f1_at[i] >= 0) && (k >= f1_at[i]);
      bus.finished2[i] = (f2_at[i] >= 0) && (k >= f2_at[i]);
    end
  endtask

  task automatic run_race(input string tag, output int n);
    bus.finished1 = '0;
    bus.finished2 = '0;
    repeat (SYNC + 1) tick();
    apply(0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (!bus.resp_valid && n < 40) begin
      n++;
      apply(n);
      tick();
    end
    check({tag, "_resp_valid"}, bus.resp_valid, 1'b1);
  endtask

  task automatic ack();
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.start      = 1'b0;
    bus.resp_ready = 1'b0;
    bus.finished1  = '0;
    bus.finished2  = '0;
    #12;
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.resp_valid, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_response", bus.response, 0);
    check("rst_tie", bus.tie, 0);
    check("rst_unresolved", bus.unresolved, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // 1: path 1 wins everywhere
    for (int i = 0; i < N; i++) begin f1_at[i] = 5; f2_at[i] = 9; end
    run_race("t1", lat);
    check("t1_latency_ok", lat <= 5 + SYNC + 2, 1);
    check("t1_busy", bus.busy, 1);
    check("t1_response", bus.response, 8'hFF);
    check("t1_tie", bus.tie, 8'h00);
    check("t1_unresolved", bus.unresolved, 8'h00);
    check("t1_timeout", bus.timeout, 0);
    ack();
    check("t1_valid_drop", bus.resp_valid, 0);
    check("t1_busy_drop", bus.busy, 0);

    // 2: alternating winners
    for (int i = 0; i < N; i++) begin
      f1_at[i] = (i % 2 == 0) ? 1 : 4;
      f2_at[i] = (i % 2 == 0) ? 4 : 1;
    end
    run_race("t2", lat);
    check("t2_response", bus.response, 8'h55);
    check("t2_tie", bus.tie, 8'h00);
    check("t2_unresolved", bus.unresolved, 8'h00);
    ack();

    // 4: channel 7 never fires
    for (int i = 0; i < N; i++) begin f1_at[i] = (i == 7) ? -1 : 0; f2_at[i] = -1; end
    run_race("t4", lat);
    check("t4_latency", lat, TMO);
    check("t4_timeout", bus.timeout, 1);
    check("t4_unresolved", bus.unresolved, 8'h80);
    check("t4_response", bus.response, 8'h7F);
    check("t4_tie", bus.tie, 8'h00);
    ack();

    // Inputs already high at start: ch0 both, others path 1
    for (int i = 0; i < N; i++) begin f1_at[i] = 0; f2_at[i] = (i == 0) ? 0 : -1; end
    run_race("t7", lat);
    check("t7_response", bus.response, 8'hFE);
    check("t7_tie", bus.tie, 8'h01);
    check("t7_timeout", bus.timeout, 0);
    ack();

    // 3: channel 3 tie, others path 2
    for (int i = 0; i < N; i++) begin
      f1_at[i] = (i == 3) ? 2 : 5;
      f2_at[i] = (i == 3) ? 2 : 1;
    end
    run_race("t3", lat);
    check("t3_tie", bus.tie, 8'h08);
    check("t3_response", bus.response, 8'h00);
    check("t3_unresolved", bus.unresolved, 8'h00);

    // 5: backpressure with stray start pulses
    for (int c = 0; c < 10; c++) begin
      bus.start = (c % 2 == 0);
      tick();
      check("t5_hold_valid", bus.resp_valid, 1);
      check("t5_hold_tie", bus.tie, 8'h08);
    end
    check("t5_hold_response", bus.response, 8'h00);
    bus.start      = 1'b1;
    bus.resp_ready = 1'b1;
    tick();
    bus.start      = 1'b0;
    bus.resp_ready = 1'b0;
    check("t5_valid_drop", bus.resp_valid, 0);
    check("t5_busy_drop", bus.busy, 0);
    tick();
    check("t5_no_rearm", bus.busy, 0);
    check("t5_data_held", bus.tie, 8'h08);

    // 6: async reset while ARMED, then a fresh race
    for (int i = 0; i < N; i++) begin f1_at[i] = -1; f2_at[i] = -1; end
    bus.finished1 = '0;
    bus.finished2 = '0;
    repeat (SYNC + 1) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    check("t6_armed_busy", bus.busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_busy", bus.busy, 0);
    check("t6_rst_valid", bus.resp_valid, 0);
    check("t6_rst_timeout", bus.timeout, 0);
    check("t6_rst_data", {bus.response, bus.tie, bus.unresolved}, 24'h0);
    tick();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < N; i++) begin
      f1_at[i] = (i % 2 == 0) ? 1 : 4;
      f2_at[i] = (i % 2 == 0) ? 4 : 1;
    end
    run_race("t6", lat);
    check("t6_response", bus.response, 8'h55);
    check("t6_timeout", bus.timeout, 0);
    ack();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
